// File: rtl/des_dec_keysched.sv
// DES key schedule for decryption: accepts a 64-bit key and streams round keys K16..K1 over a valid/ready handshake.
// Optional byte-parity check of the accepted key is enabled by defining KEYSCHED_PARITY_CHK_EN.
module des_dec_keysched (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [63:0] key_i,
    input  logic        key_valid_i,
    output logic        key_ready_o,
    output logic [47:0] round_key_o,
    output logic [3:0]  round_idx_o,
    output logic        rk_valid_o,
    input  logic        rk_ready_i,
    output logic        busy_o,
    output logic        done_o,
    input  logic        abort_i
`ifdef KEYSCHED_PARITY_CHK_EN
    ,
    output logic        parity_err_o
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  idx_q, idx_d;
    logic        done_q, done_d;

    // Key bit index = 64 - FIPS position, so FIPS bit 1 is key[63]; parity bits (8, 16, ...) are dropped.
    function automatic logic [55:0] pc1(input logic [63:0] key);
        pc1 = {
            key[7],  key[15], key[23], key[31], key[39], key[47], key[55],
            key[63], key[6],  key[14], key[22], key[30], key[38], key[46],
            key[54], key[62], key[5],  key[13], key[21], key[29], key[37],
            key[45], key[53], key[61], key[4],  key[12], key[20], key[28],
            key[1],  key[9],  key[17], key[25], key[33], key[41], key[49],
            key[57], key[2],  key[10], key[18], key[26], key[34], key[42],
            key[50], key[58], key[3],  key[11], key[19], key[27], key[35],
            key[43], key[51], key[59], key[36], key[44], key[52], key[60]
        };
    endfunction

    // CD bit index = 56 - FIPS position, so C bit 1 is cd[55].
    function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
        logic [55:0] cd;
        cd  = {c, d};
        pc2 = {
            cd[42], cd[39], cd[45], cd[32], cd[55], cd[51], cd[53], cd[28],
            cd[41], cd[50], cd[35], cd[46], cd[33], cd[37], cd[44], cd[52],
            cd[30], cd[48], cd[40], cd[49], cd[29], cd[36], cd[43], cd[54],
            cd[15], cd[4],  cd[25], cd[19], cd[9],  cd[1],  cd[26], cd[16],
            cd[5],  cd[11], cd[23], cd[8],  cd[12], cd[7],  cd[17], cd[0],
            cd[22], cd[3],  cd[10], cd[14], cd[6],  cd[20], cd[27], cd[24]
        };
    endfunction

    function automatic logic [27:0] rotr1(input logic [27:0] x);
        rotr1 = {x[0], x[27:1]};
    endfunction

    function automatic logic [27:0] rotr2(input logic [27:0] x);
        rotr2 = {x[1:0], x[27:2]};
    endfunction

    // Flags a key in which any byte carries even parity.
    function automatic logic byte_parity_err(input logic [63:0] key);
        byte_parity_err = (~^key[63:56]) | (~^key[55:48]) | (~^key[47:40]) | (~^key[39:32])
                        | (~^key[31:24]) | (~^key[23:16]) | (~^key[15:8])  | (~^key[7:0]);
    endfunction

`ifdef KEYSCHED_PARITY_CHK_EN
    logic par_err_q, par_err_d;
`endif

    // Next-state logic: key acceptance, per-round right rotation, completion and abort.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
`ifdef KEYSCHED_PARITY_CHK_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (key_valid_i) begin
                    state_d = ST_EMIT;
                    {c_d, d_d} = pc1(key_i);
                    idx_d   = 4'd15;
`ifdef KEYSCHED_PARITY_CHK_EN
                    par_err_d = byte_parity_err(key_i);
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (rk_ready_i) begin
                    if (idx_q == 4'd0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // Undo the encryption shift of round idx_q+1: single for rounds 16, 9 and 2.
                        if ((idx_q == 4'd15) || (idx_q == 4'd8) || (idx_q == 4'd1)) begin
                            c_d = rotr1(c_q);
                            d_d = rotr1(d_q);
                        end else begin
                            c_d = rotr2(c_q);
                            d_d = rotr2(d_q);
                        end
                        idx_d = idx_q - 4'd1;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and key-register update with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            c_q     <= 28'd0;
            d_q     <= 28'd0;
            idx_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

`ifdef KEYSCHED_PARITY_CHK_EN
    // Parity flag register, updated only at key acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign parity_err_o = par_err_q;
`endif

    assign key_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q == ST_EMIT);
    assign rk_valid_o  = (state_q == ST_EMIT);
    assign round_idx_o = idx_q;
    assign round_key_o = pc2(c_q, d_q);
    assign done_o      = done_q;

endmodule

// File: tb/tb_des_dec_keysched.sv
// Self-checking bench for des_dec_keysched: directed scenarios plus random keys/backpressure,
// compared against a forward-shift DES key schedule model.
module tb_des_dec_keysched;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [63:0] key_i;
    logic        key_valid_i;
    logic        key_ready_o;
    logic [47:0] round_key_o;
    logic [3:0]  round_idx_o;
    logic        rk_valid_o;
    logic        rk_ready_i;
    logic        busy_o;
    logic        done_o;
    logic        abort_i;
`ifdef KEYSCHED_PARITY_CHK_EN
    logic        parity_err_o;
`endif

    int checks = 0;
    int errors = 0;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
        23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    des_dec_keysched dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .key_i       (key_i),
        .key_valid_i (key_valid_i),
        .key_ready_o (key_ready_o),
        .round_key_o (round_key_o),
        .round_idx_o (round_idx_o),
        .rk_valid_o  (rk_valid_o),
        .rk_ready_i  (rk_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .abort_i     (abort_i)
`ifdef KEYSCHED_PARITY_CHK_EN
        ,
        .parity_err_o(parity_err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Standard forward schedule: K_n from C_n/D_n after n left shifts.
    function automatic logic [47:0] model_k(input logic [63:0] key, input int n);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] k;
        int sh;
        for (int i = 0; i < 28; i++) begin
            c[27 - i] = key[64 - PC1_T[i]];
            d[27 - i] = key[64 - PC1_T[28 + i]];
        end
        for (int r = 1; r <= n; r++) begin
            sh = (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
            for (int s = 0; s < sh; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[47 - i] = cd[56 - PC2_T[i]];
        return k;
    endfunction

    function automatic logic model_par(input logic [63:0] key);
        for (int b = 0; b < 8; b++)
            if (($countones(key[8*b +: 8]) % 2) == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // mode: 0 = run to completion, 1 = abort at evt_at, 2 = reset at evt_at.
    task automatic run_sched(input logic [63:0] key, input int stall_at, input int stall_len,
                             input bit rnd, input int mode, input int evt_at, input bit hold_other,
                             output logic [47:0] first_k, output logic [47:0] last_k, output int hs);
        logic [47:0] exp_k [16];
        int  e, stalled, cyc;
        bit  finished, ready;
        for (int n = 0; n < 16; n++) exp_k[n] = model_k(key, n + 1);
        first_k = 48'd0; last_k = 48'd0; hs = 0;
        chk("ready_before_accept", {63'd0, key_ready_o}, 64'd1);
        key_i = key; key_valid_i = 1'b1; rk_ready_i = 1'b0;
        tick();
        if (hold_other) key_i = ~key; else key_valid_i = 1'b0;
`ifdef KEYSCHED_PARITY_CHK_EN
        chk("parity_err", {63'd0, parity_err_o}, {63'd0, model_par(key)});
`endif
        e = 15; stalled = 0; cyc = 0; finished = 1'b0;
        while (!finished && cyc < 400) begin
            cyc++;
            chk("emit", {8'h00, rk_valid_o, busy_o, key_ready_o, done_o, round_idx_o, round_key_o},
                {8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'(e), exp_k[e]});
            if (e == 15) first_k = round_key_o;
            if (e == 0) last_k = round_key_o;
            if (mode == 1 && e == evt_at) begin
                abort_i = 1'b1; rk_ready_i = 1'b1;
                tick();
                abort_i = 1'b0; rk_ready_i = 1'b0;
                chk("abort", {60'd0, rk_valid_o, busy_o, key_ready_o, done_o}, 64'b0010);
                finished = 1'b1;
            end else if (mode == 2 && e == evt_at) begin
                rst_ni = 1'b0;
                #1;
                chk("reset_async", {8'h00, rk_valid_o, busy_o, key_ready_o, done_o, round_idx_o, round_key_o},
                    {8'h00, 4'b0010, 4'd0, 48'd0});
                tick();
                chk("reset_hold", {8'h00, rk_valid_o, busy_o, key_ready_o, done_o, round_idx_o, round_key_o},
                    {8'h00, 4'b0010, 4'd0, 48'd0});
                rst_ni = 1'b1;
                finished = 1'b1;
            end else begin
                if (rnd) ready = 1'($urandom_range(0, 1));
                else ready = !(e == stall_at && stalled < stall_len);
                if (!ready) stalled++;
                rk_ready_i = ready;
                tick();
                if (ready) begin
                    hs++;
                    if (e == 0) begin
                        chk("done", {60'd0, rk_valid_o, busy_o, key_ready_o, done_o}, 64'b0011);
                        finished = 1'b1;
                    end else begin
                        e--;
                    end
                end
            end
        end
        chk("sched_finished", {63'd0, finished}, 64'd1);
        key_valid_i = 1'b0; rk_ready_i = 1'b0;
    endtask

    task automatic idle_tick();
        tick();
        chk("idle_after", {60'd0, rk_valid_o, busy_o, key_ready_o, done_o}, 64'b0010);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] fk, lk;
        int          hs;
        logic [63:0] rkey;
        rst_ni = 1'b0; key_i = 64'd0; key_valid_i = 1'b0; rk_ready_i = 1'b0; abort_i = 1'b0;
        repeat (3) tick();
        chk("reset_state", {8'h00, rk_valid_o, busy_o, key_ready_o, done_o, round_idx_o, round_key_o},
            {8'h00, 4'b0010, 4'd0, 48'd0});
`ifdef KEYSCHED_PARITY_CHK_EN
        chk("reset_parity", {63'd0, parity_err_o}, 64'd0);
`endif
        rst_ni = 1'b1;
        tick();

        // Known vector, full-rate consumer.
        run_sched(64'h133457799BBCDFF1, -1, 0, 1'b0, 0, -1, 1'b0, fk, lk, hs);
        chk("vec_k16", {16'd0, fk}, {16'd0, 48'hCB3D8B0E17F5});
        chk("vec_k1", {16'd0, lk}, {16'd0, 48'h1B02EFFC7072});
        chk("vec_hs", 64'(hs), 64'd16);
        idle_tick();

        // Backpressure at idx 12 for five cycles.
        run_sched(64'h133457799BBCDFF1, 12, 5, 1'b0, 0, -1, 1'b0, fk, lk, hs);
        chk("stall_hs", 64'(hs), 64'd16);
        idle_tick();

        // Abort at idx 7, then a fresh schedule must restart at K16.
        run_sched(64'h133457799BBCDFF1, -1, 0, 1'b0, 1, 7, 1'b0, fk, lk, hs);
        idle_tick();
        run_sched(64'h133457799BBCDFF1, -1, 0, 1'b0, 0, -1, 1'b0, fk, lk, hs);
        chk("restart_k16", {16'd0, fk}, {16'd0, 48'hCB3D8B0E17F5});
        idle_tick();

        // Reset at idx 4, then an all-parity-bit key gives all-zero round keys.
        run_sched(64'h133457799BBCDFF1, -1, 0, 1'b0, 2, 4, 1'b0, fk, lk, hs);
        run_sched(64'h0101010101010101, -1, 0, 1'b0, 0, -1, 1'b0, fk, lk, hs);
        chk("zero_first", {16'd0, fk}, 64'd0);
        chk("zero_last", {16'd0, lk}, 64'd0);
        idle_tick();

        // key_valid held with another key during EMIT, then a back-to-back key in the done cycle.
        run_sched(64'h133457799BBCDFF1, -1, 0, 1'b0, 0, -1, 1'b1, fk, lk, hs);
        run_sched(64'h0E329232EA6D0D73, -1, 0, 1'b0, 0, -1, 1'b0, fk, lk, hs);
        chk("b2b_hs", 64'(hs), 64'd16);
        idle_tick();

        // Key with an even-parity byte.
        run_sched(64'h123457799BBCDFF1, -1, 0, 1'b0, 0, -1, 1'b0, fk, lk, hs);
`ifdef KEYSCHED_PARITY_CHK_EN
        chk("parity_held", {63'd0, parity_err_o}, 64'd1);
`endif
        idle_tick();

        // Random keys with random backpressure, occasional back-to-back or abort.
        for (int it = 0; it < 8; it++) begin
            rkey = {$urandom, $urandom};
            if (it == 5)
                run_sched(rkey, -1, 0, 1'b1, 1, int'($urandom_range(0, 15)), 1'b0, fk, lk, hs);
            else
                run_sched(rkey, -1, 0, 1'b1, 0, -1, 1'b0, fk, lk, hs);
            if (it % 2 == 1) idle_tick();
        end
        idle_tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
